vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing on vga_clk (25 MHz pixel clock). Drives DrawX/DrawY/blank to the pixel-colour stages (sprite/background ROM + palette blocks), which compute colour from coordinates. hsync/vsync go to the VGA connector. They are delayed by a parameterised number of cycles so they match the colour stages' registered ROM/palette latency.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks); H_TOTAL = sum = 800
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines); V_TOTAL = sum = 525
PIPE_DELAY, 2, cycles of delay on hsync/vsync relative to DrawX/DrawY (legal 0..4)

Ports:
vga_clk  input  1  pixel clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
DrawX  output  10  current column counter, 0..H_TOTAL-1
DrawY  output  10  current line counter, 0..V_TOTAL-1
blank  output  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE), 0 = blanking; aligned with DrawX/DrawY
hsync  output  1  active-low horizontal sync, delayed PIPE_DELAY cycles
vsync  output  1  active-low vertical sync, delayed PIPE_DELAY cycles
line_start  output  1  one-cycle pulse when DrawX==0 (aligned with DrawX)
frame_start  output  1  one-cycle pulse when DrawX==0 and DrawY==0 (aligned with DrawX)

Behaviour:
- Reset (reset_n low, async): hc=0, vc=0, run=0; every hsync/vsync delay stage = 1. Outputs during reset: DrawX=0, DrawY=0, blank=0, hsync=1, vsync=1, line_start=0, frame_start=0.
- run flag: set on the first rising edge with reset_n high. hc/vc hold at 0 on that edge. Counting starts on the following edge. The first counted cycle therefore presents (0,0) with run=1.
- hc increments each clock while run=1. At H_TOTAL-1 it wraps to 0, and vc increments on the same edge. At vc==V_TOTAL-1 and hc==H_TOTAL-1, both wrap to 0.
- DrawX=hc and DrawY=vc, driven directly from the registers. No arithmetic beyond the 10-bit compare/increment. Widths must hold 799 and 524.
- blank = run & (hc<H_VISIBLE) & (vc<V_VISIBLE). Combinational from the registers, zero latency relative to DrawX/DrawY.
- Raw syncs, combinational from the counters:
  - hs_raw = 0 when H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751), else 1.
  - vs_raw = 0 when V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491), else 1.
  - Both are forced to 1 while run=0.
- hsync/vsync equal hs_raw/vs_raw delayed by exactly PIPE_DELAY clocks through a shift register reset to 1. With PIPE_DELAY=0 they equal the raw values with no register.
- line_start = run & (hc==0). frame_start = run & (hc==0) & (vc==0). frame_start implies line_start.
- Reset mid-frame: everything returns asynchronously to reset values. After release, the sequence restarts from (0,0) with the run-flag one-cycle hold. No partial sync pulse may appear: the delay line is forced to 1.
- Frame period: exactly 800*525 = 420000 clocks between frame_start pulses. 800 clocks between line_start pulses.

Decomposition:
- Package vga_timing_pkg: H_*/V_* default constants, derived H_TOTAL/V_TOTAL, and sync-start/end localparams. The colour stages share these constants.
- One sub-module, sync_delay: a parameterised 1-bit shift register with reset value 1 and depth PIPE_DELAY. Instantiated twice, for hsync and vsync.

Test Plan:
- Reset release: hold reset_n low 5 clocks, then release. Required: blank=0, hsync=vsync=1 during reset; the first post-reset edge holds (0,0); the next cycle shows DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1.
- Horizontal timing: count from line_start. Required: blank=1 for 640 clocks; hs_raw low at hc=656..751 (96 clocks); hsync falls at hc=658 with PIPE_DELAY=2; next line_start after 800 clocks with DrawY incremented by 1.
- Wrap-around: run to DrawX=799, DrawY=524. Required: next cycle DrawX=0, DrawY=0, frame_start=1; the gap between consecutive frame_start pulses is 420000 clocks.
- Vertical sync/blanking: required vsync low for exactly 1600 clocks starting at DrawY=490, DrawX=2 (delay 2); blank=0 for all lines 480..524.
- Mid-frame reset: assert reset_n low at DrawX=700, DrawY=300, while hsync is low. Required: immediate hsync=1, DrawX=DrawY=0, blank=0; after release, a clean restart as in the reset-release case.
- Parameter sweep: PIPE_DELAY=0 and 4. Required: the hsync falling edge occurs at hc=656 and hc=660 respectively; DrawX/blank timing is unchanged.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 raster constants shared by the timing generator
// and the pixel-colour stages.
package vga_timing_pkg;

   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FRONT   = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BACK    = 48;
   localparam int unsigned H_TOTAL   =
      H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int unsigned V_VISIBLE = 480;
   localparam int unsigned V_FRONT   = 10;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 33;
   localparam int unsigned V_TOTAL   =
      V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int unsigned CNT_W = 10;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic {
      ST_HOLD = 1'b0,
      ST_RUN  = 1'b1
   } run_state_e;

   // Half-open window test [lo, hi) used for both sync pulses.
   function automatic logic in_window(
      input cnt_t v,
      input cnt_t lo,
      input cnt_t hi
   );
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the timing generator to the colour stages
// and the VGA connector.
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   cnt_t DrawX;
   cnt_t DrawY;
   logic blank;
   logic hsync;
   logic vsync;
   logic line_start;
   logic frame_start;

   modport master (
      output DrawX,
      output DrawY,
      output blank,
      output hsync,
      output vsync,
      output line_start,
      output frame_start
   );

   modport slave (
      input DrawX,
      input DrawY,
      input blank,
      input hsync,
      input vsync,
      input line_start,
      input frame_start
   );

endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// 1-bit shift register that idles high, used to line the syncs
// up with the registered colour pipeline.
module sync_delay #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   if (DEPTH == 0) begin : g_wire
      logic unused_clk;
      assign unused_clk = clk_i ^ rst_ni;
      assign q_o        = d_i;
   end else begin : g_sr
      logic [DEPTH-1:0] sr_q;
      logic [DEPTH-1:0] sr_d;

      if (DEPTH == 1) begin : g_one
         assign sr_d = d_i;
      end else begin : g_many
         assign sr_d = {sr_q[DEPTH-2:0], d_i};
      end

      // Reset to all-ones so no partial sync pulse leaks out.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            sr_q <= '1;
         end else begin
            sr_q <= sr_d;
         end
      end

      assign q_o = sr_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, blanking and delayed sync generation for the
// VGA pixel clock domain.
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
   parameter int unsigned H_FRONT    = vga_timing_pkg::H_FRONT,
   parameter int unsigned H_SYNC     = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BACK     = vga_timing_pkg::H_BACK,
   parameter int unsigned V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
   parameter int unsigned V_FRONT    = vga_timing_pkg::V_FRONT,
   parameter int unsigned V_SYNC     = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BACK     = vga_timing_pkg::V_BACK,
   parameter int unsigned PIPE_DELAY = 2
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   vga_timing_gen_if.master vga_o
);
   import vga_timing_pkg::*;

   localparam int unsigned HT =
      H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned VT =
      V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam cnt_t H_LAST = cnt_t'(HT - 1);
   localparam cnt_t V_LAST = cnt_t'(VT - 1);
   localparam cnt_t H_VIS  = cnt_t'(H_VISIBLE);
   localparam cnt_t V_VIS  = cnt_t'(V_VISIBLE);
   localparam cnt_t HS_LO  = cnt_t'(H_VISIBLE + H_FRONT);
   localparam cnt_t HS_HI  = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam cnt_t VS_LO  = cnt_t'(V_VISIBLE + V_FRONT);
   localparam cnt_t VS_HI  = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam cnt_t ONE    = cnt_t'(1);

   run_state_e state_q;
   run_state_e state_d;
   cnt_t       hc_q;
   cnt_t       hc_d;
   cnt_t       vc_q;
   cnt_t       vc_d;
   logic       run;
   logic       hs_raw;
   logic       vs_raw;
   logic       hsync_dly;
   logic       vsync_dly;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_HOLD;
         hc_q    <= '0;
         vc_q    <= '0;
      end else begin
         state_q <= state_d;
         hc_q    <= hc_d;
         vc_q    <= vc_d;
      end
   end

   // The edge that leaves ST_HOLD keeps (0,0) so the first counted
   // cycle still presents the origin.
   always_comb begin
      state_d = state_q;
      hc_d    = hc_q;
      vc_d    = vc_q;
      unique case (state_q)
         ST_HOLD: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (hc_q == H_LAST) begin
               hc_d = '0;
               if (vc_q == V_LAST) begin
                  vc_d = '0;
               end else begin
                  vc_d = vc_q + ONE;
               end
            end else begin
               hc_d = hc_q + ONE;
            end
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase
   end

   assign run = (state_q == ST_RUN);

   assign hs_raw = ~(run & in_window(hc_q, HS_LO, HS_HI));
   assign vs_raw = ~(run & in_window(vc_q, VS_LO, VS_HI));

   sync_delay #(
      .DEPTH (PIPE_DELAY)
   ) u_hs_dly (
      .clk_i  (vga_clk),
      .rst_ni (reset_n),
      .d_i    (hs_raw),
      .q_o    (hsync_dly)
   );

   sync_delay #(
      .DEPTH (PIPE_DELAY)
   ) u_vs_dly (
      .clk_i  (vga_clk),
      .rst_ni (reset_n),
      .d_i    (vs_raw),
      .q_o    (vsync_dly)
   );

   assign vga_o.DrawX       = hc_q;
   assign vga_o.DrawY       = vc_q;
   assign vga_o.blank       = run & (hc_q < H_VIS) & (vc_q < V_VIS);
   assign vga_o.hsync       = hsync_dly;
   assign vga_o.vsync       = vsync_dly;
   assign vga_o.line_start  = run & (hc_q == '0);
   assign vga_o.frame_start = run & (hc_q == '0) & (vc_q == '0);

endmodule
